// File: rtl/bd_in_handshaker_pkg.sv
// rtl/bd_in_handshaker_pkg.sv - shared definitions for the BD input handshaker
//
// Holds the handshake FSM state encoding, the BD word width shared with the
// BD word decoder, and the default depth of the request synchronizer.
package bd_in_handshaker_pkg;

   // BD word width; the decoder input channel uses this same constant.
   localparam int BD_NBITS = 34;

   // Default number of flops in the asynchronous request synchronizer.
   localparam int BD_SYNC_STAGES_DEF = 2;

   typedef enum logic [1:0] {
      ST_RESYNC = 2'd0,
      ST_IDLE   = 2'd1,
      ST_ACKED  = 2'd2
   } bd_in_state_e;

endpackage

// File: rtl/bd_in_handshaker_if.sv
// rtl/bd_in_handshaker_if.sv - valid/ack word channel from the handshaker to the decoder
//
// Signals:
//   v  valid, driven by the master
//   d  NBITS-wide word, driven by the master, stable while v is high
//   a  acknowledge, driven by the slave; a transfer occurs on a cycle with v && a
interface bd_in_handshaker_if
   import bd_in_handshaker_pkg::*;
#(
   parameter int NBITS = BD_NBITS
);
   logic             v;
   logic [NBITS-1:0] d;
   logic             a;

   modport master (output v, output d, input a);
   modport slave  (input v, input d, output a);
endinterface

// File: rtl/bd_sync_bit.sv
// rtl/bd_sync_bit.sv - N-stage single-bit synchronizer for asynchronous BD inputs
//
// Ports:
//   clk     destination clock
//   resetn  synchronous active-low reset; all stages clear to 0
//   d       asynchronous input bit
//   q       synchronized output, STAGES clk edges after d
module bd_sync_bit #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic resetn,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] sync_q;
   logic [STAGES-1:0] sync_d;

   always_comb begin
      sync_d = {sync_q[STAGES-2:0], d};
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         sync_q <= '0;
      end else begin
         sync_q <= sync_d;
      end
   end

   assign q = sync_q[STAGES-1];

endmodule

// File: rtl/bd_in_handshaker.sv
// rtl/bd_in_handshaker.sv - 4-phase bundled-data BD output port to clocked valid/ack channel
//
// Synchronizes BD's request, captures the bundled word into a registered
// output stage and drives BD's acknowledge. A word is accepted only when the
// output register is empty or is being drained in the same cycle.
//
// Optional feature macro: BD_IN_COUNT_EN adds the words_received counter port.
//
// Ports:
//   clk             system clock
//   reset           synchronous active-low reset
//   pin_req         BD request, asynchronous to clk
//   pin_data        BD word, bundled with pin_req
//   pin_ack         registered acknowledge to BD
//   BD_out          master side of the valid/ack word channel
//   words_received  captured-word count, wraps mod 2^32 (BD_IN_COUNT_EN only)
module bd_in_handshaker
   import bd_in_handshaker_pkg::*;
#(
   parameter int SYNC_STAGES = BD_SYNC_STAGES_DEF,
   parameter int NBITS       = BD_NBITS
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   pin_req,
   input  logic [NBITS-1:0]       pin_data,
   output logic                   pin_ack,
   bd_in_handshaker_if.master     BD_out
`ifdef BD_IN_COUNT_EN
   ,
   output logic [31:0]            words_received
`endif
);

   localparam int FW = $clog2(SYNC_STAGES + 1);
   localparam logic [FW-1:0] FILL_DONE = FW'(SYNC_STAGES);

   bd_in_state_e     state_q, state_d;
   logic             ack_q, ack_d;
   logic             v_q, v_d;
   logic [NBITS-1:0] data_q, data_d;
   logic [FW-1:0]    fill_q, fill_d;

   logic req_s;
   logic capture;
   logic xfer;

   bd_sync_bit #(.STAGES(SYNC_STAGES)) u_req_sync (
      .clk    (clk),
      .resetn (reset),
      .d      (pin_req),
      .q      (req_s)
   );

   // The synchronizer clears to 0 on reset, which would falsely read as
   // "req low". RESYNC only trusts req_s once every stage holds a real
   // post-reset sample, so a word BD is still holding is never recaptured.
   always_comb begin
      fill_d = fill_q;
      if (fill_q != FILL_DONE) begin
         fill_d = fill_q + FW'(1);
      end
   end

   assign xfer    = v_q && BD_out.a;
   assign capture = (state_q == ST_IDLE) && req_s && (!v_q || BD_out.a);

   always_comb begin
      state_d = state_q;
      ack_d   = ack_q;
      v_d     = v_q;
      data_d  = data_q;

      unique case (state_q)
         ST_RESYNC: begin
            if ((fill_q == FILL_DONE) && !req_s) begin
               state_d = ST_IDLE;
            end
         end
         ST_IDLE: begin
            if (capture) begin
               state_d = ST_ACKED;
               ack_d   = 1'b1;
            end
         end
         ST_ACKED: begin
            // A new req rise cannot occur before ack falls in a 4-phase
            // handshake, so only the falling edge of req_s matters here.
            if (!req_s) begin
               state_d = ST_IDLE;
               ack_d   = 1'b0;
            end
         end
         default: begin
            state_d = ST_RESYNC;
            ack_d   = 1'b0;
         end
      endcase

      // Capture wins over transfer so a same-cycle drain and refill keeps v high.
      if (capture) begin
         data_d = pin_data;
         v_d    = 1'b1;
      end else if (xfer) begin
         v_d    = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= ST_RESYNC;
         ack_q   <= 1'b0;
         v_q     <= 1'b0;
         data_q  <= '0;
         fill_q  <= '0;
      end else begin
         state_q <= state_d;
         ack_q   <= ack_d;
         v_q     <= v_d;
         data_q  <= data_d;
         fill_q  <= fill_d;
      end
   end

`ifdef BD_IN_COUNT_EN
   logic [31:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (capture) begin
         count_d = count_q + 32'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign words_received = count_q;
`endif

   assign pin_ack  = ack_q;
   assign BD_out.v = v_q;
   assign BD_out.d = data_q;

endmodule

// File: tb/tb_bd_in_handshaker.sv
// tb/tb_bd_in_handshaker.sv - self-checking bench for bd_in_handshaker
module tb_bd_in_handshaker;
   import bd_in_handshaker_pkg::*;

   localparam int NB = BD_NBITS;

   logic          clk;
   logic          reset;
   logic          pin_req;
   logic [NB-1:0] pin_data;
   logic          pin_ack;
`ifdef BD_IN_COUNT_EN
   logic [31:0]   words_received;
`endif

   int tests_run    = 0;
   int tests_failed = 0;

   bd_in_handshaker_if #(.NBITS(NB)) bd_if ();

   bd_in_handshaker #(.SYNC_STAGES(2), .NBITS(NB)) dut (
      .clk      (clk),
      .reset    (reset),
      .pin_req  (pin_req),
      .pin_data (pin_data),
      .pin_ack  (pin_ack),
      .BD_out   (bd_if)
`ifdef BD_IN_COUNT_EN
      ,
      .words_received (words_received)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   logic [NB-1:0] got_q[$];
   bit            mon_en = 1'b0;

   always @(negedge clk) begin
      if (mon_en && bd_if.v === 1'b1 && bd_if.a === 1'b1) got_q.push_back(bd_if.d);
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic test_reset;
      reset = 1'b0; pin_req = 1'b0; pin_data = '0; bd_if.a = 1'b0;
      tick(2);
      tests_run++;
      if (pin_ack !== 1'b0 || bd_if.v !== 1'b0 || bd_if.d !== '0) begin
         tests_failed++;
         $display("FAIL reset_state: ack=%b v=%b d=%h expected 0 0 0", pin_ack, bd_if.v, bd_if.d);
      end
`ifdef BD_IN_COUNT_EN
      tests_run++;
      if (words_received !== 32'd0) begin
         tests_failed++;
         $display("FAIL reset_count: got %0d expected 0", words_received);
      end
`endif
      reset = 1'b1;
      tick(4);
   endtask

   task automatic test_single;
      bd_if.a = 1'b1;
      pin_data = 34'h2_DEAD_BEEF; pin_req = 1'b1;
      tick(2);
      tests_run++;
      if (pin_ack !== 1'b0 || bd_if.v !== 1'b0) begin
         tests_failed++;
         $display("FAIL single_pre: ack=%b v=%b expected 0 0", pin_ack, bd_if.v);
      end
      tick(1);
      tests_run++;
      if (pin_ack !== 1'b1 || bd_if.v !== 1'b1 || bd_if.d !== 34'h2_DEAD_BEEF) begin
         tests_failed++;
         $display("FAIL single_capture: ack=%b v=%b d=%h expected 1 1 2deadbeef", pin_ack, bd_if.v, bd_if.d);
      end
      tick(1);
      tests_run++;
      if (bd_if.v !== 1'b0 || pin_ack !== 1'b1) begin
         tests_failed++;
         $display("FAIL single_v_one_cycle: v=%b ack=%b expected 0 1", bd_if.v, pin_ack);
      end
      pin_req = 1'b0;
      tick(2);
      tests_run++;
      if (pin_ack !== 1'b1) begin
         tests_failed++;
         $display("FAIL single_ack_hold: ack=%b expected 1", pin_ack);
      end
      tick(1);
      tests_run++;
      if (pin_ack !== 1'b0) begin
         tests_failed++;
         $display("FAIL single_ack_fall: ack=%b expected 0", pin_ack);
      end
      tick(3);
   endtask

   task automatic test_backpressure;
      bd_if.a = 1'b0;
      pin_data = 34'h1_1111_2222; pin_req = 1'b1;
      tick(3);
      tests_run++;
      if (pin_ack !== 1'b1 || bd_if.v !== 1'b1 || bd_if.d !== 34'h1_1111_2222) begin
         tests_failed++;
         $display("FAIL bp_first: ack=%b v=%b d=%h expected 1 1 111112222", pin_ack, bd_if.v, bd_if.d);
      end
      pin_req = 1'b0;
      tick(3);
      pin_data = 34'h3_3333_4444; pin_req = 1'b1;
      tick(6);
      tests_run++;
      if (pin_ack !== 1'b0 || bd_if.v !== 1'b1 || bd_if.d !== 34'h1_1111_2222) begin
         tests_failed++;
         $display("FAIL bp_stall: ack=%b v=%b d=%h expected 0 1 111112222", pin_ack, bd_if.v, bd_if.d);
      end
      bd_if.a = 1'b1;
      tick(1);
      tests_run++;
      if (pin_ack !== 1'b1 || bd_if.v !== 1'b1 || bd_if.d !== 34'h3_3333_4444) begin
         tests_failed++;
         $display("FAIL bp_drain: ack=%b v=%b d=%h expected 1 1 333334444", pin_ack, bd_if.v, bd_if.d);
      end
      tick(1);
      tests_run++;
      if (bd_if.v !== 1'b0) begin
         tests_failed++;
         $display("FAIL bp_no_dup: v=%b expected 0", bd_if.v);
      end
      pin_req = 1'b0;
      tick(5);
   endtask

   task automatic test_simultaneous;
      bd_if.a = 1'b0;
      pin_data = 34'h0_0000_00A5; pin_req = 1'b1;
      tick(3);
      pin_req = 1'b0;
      tick(3);
      pin_data = 34'h3_FFFF_005A; pin_req = 1'b1;
      tick(2);
      tests_run++;
      if (pin_ack !== 1'b0 || bd_if.v !== 1'b1 || bd_if.d !== 34'h0_0000_00A5) begin
         tests_failed++;
         $display("FAIL simul_pre: ack=%b v=%b d=%h expected 0 1 0000000a5", pin_ack, bd_if.v, bd_if.d);
      end
      bd_if.a = 1'b1;
      tick(1);
      tests_run++;
      if (bd_if.v !== 1'b1 || bd_if.d !== 34'h3_FFFF_005A || pin_ack !== 1'b1) begin
         tests_failed++;
         $display("FAIL simul_update: v=%b d=%h ack=%b expected 1 3ffff005a 1", bd_if.v, bd_if.d, pin_ack);
      end
      tick(1);
      tests_run++;
      if (bd_if.v !== 1'b0) begin
         tests_failed++;
         $display("FAIL simul_drain: v=%b expected 0", bd_if.v);
      end
      pin_req = 1'b0;
      tick(5);
   endtask

   task automatic test_reset_mid;
      bd_if.a = 1'b0;
      pin_data = 34'h2_5555_AAAA; pin_req = 1'b1;
      tick(3);
      tests_run++;
      if (pin_ack !== 1'b1 || bd_if.v !== 1'b1) begin
         tests_failed++;
         $display("FAIL rmid_acked: ack=%b v=%b expected 1 1", pin_ack, bd_if.v);
      end
      reset = 1'b0;
      tick(1);
      tests_run++;
      if (pin_ack !== 1'b0 || bd_if.v !== 1'b0 || bd_if.d !== '0) begin
         tests_failed++;
         $display("FAIL rmid_cleared: ack=%b v=%b d=%h expected 0 0 0", pin_ack, bd_if.v, bd_if.d);
      end
      reset = 1'b1;
      tick(8);
      tests_run++;
      if (pin_ack !== 1'b0 || bd_if.v !== 1'b0) begin
         tests_failed++;
         $display("FAIL rmid_no_recapture: ack=%b v=%b expected 0 0", pin_ack, bd_if.v);
      end
      pin_req = 1'b0;
      tick(6);
      tests_run++;
      if (pin_ack !== 1'b0 || bd_if.v !== 1'b0) begin
         tests_failed++;
         $display("FAIL rmid_idle: ack=%b v=%b expected 0 0", pin_ack, bd_if.v);
      end
      pin_data = 34'h1_2345_6789; pin_req = 1'b1;
      tick(3);
      tests_run++;
      if (pin_ack !== 1'b1 || bd_if.v !== 1'b1 || bd_if.d !== 34'h1_2345_6789) begin
         tests_failed++;
         $display("FAIL rmid_next: ack=%b v=%b d=%h expected 1 1 123456789", pin_ack, bd_if.v, bd_if.d);
      end
      bd_if.a = 1'b1; pin_req = 1'b0;
      tick(5);
   endtask

   task automatic test_back_to_back;
      logic [NB-1:0] exp_q[$];
      logic [NB-1:0] w;
      int            errs;
      reset = 1'b0; bd_if.a = 1'b1; pin_req = 1'b0;
      tick(1);
      reset = 1'b1;
      tick(4);
      got_q.delete();
      mon_en = 1'b1;
      for (int i = 0; i < 100; i++) begin
         w[NB-1:32] = 2'($urandom_range(3, 0));
         w[31:0]    = $urandom();
         exp_q.push_back(w);
         pin_data = w; pin_req = 1'b1;
         for (int k = 0; k < 20 && pin_ack !== 1'b1; k++) tick(1);
         tests_run++;
         if (pin_ack !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_ack_rise word %0d: ack=%b expected 1", i, pin_ack);
         end
         pin_req = 1'b0;
         for (int k = 0; k < 20 && pin_ack !== 1'b0; k++) tick(1);
         tests_run++;
         if (pin_ack !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_ack_fall word %0d: ack=%b expected 0", i, pin_ack);
         end
      end
      tick(4);
      mon_en = 1'b0;
      tests_run++;
      if (got_q.size() != 100) begin
         tests_failed++;
         $display("FAIL b2b_count: got %0d words expected 100", got_q.size());
      end
      errs = 0;
      for (int i = 0; i < 100 && i < got_q.size(); i++) begin
         if (got_q[i] !== exp_q[i]) begin
            if (errs < 5) $display("FAIL b2b_word %0d: got %h expected %h", i, got_q[i], exp_q[i]);
            errs++;
         end
      end
      tests_run++;
      if (errs != 0) begin
         tests_failed++;
         $display("FAIL b2b_order: %0d words differ, expected 0", errs);
      end
`ifdef BD_IN_COUNT_EN
      tests_run++;
      if (words_received !== 32'd100) begin
         tests_failed++;
         $display("FAIL b2b_words_received: got %0d expected 100", words_received);
      end
`endif
   endtask

`ifdef BD_IN_COUNT_EN
   task automatic test_counter_wrap;
      bd_if.a = 1'b1;
      force dut.count_q = 32'hFFFF_FFFF;
      tick(1);
      release dut.count_q;
      tick(1);
      pin_data = 34'h0_CAFE_F00D; pin_req = 1'b1;
      tick(3);
      pin_req = 1'b0;
      tick(4);
      tests_run++;
      if (words_received !== 32'd0) begin
         tests_failed++;
         $display("FAIL counter_wrap: got %h expected 00000000", words_received);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_backpressure();
      test_simultaneous();
      test_reset_mid();
      test_back_to_back();
`ifdef BD_IN_COUNT_EN
      test_counter_wrap();
`endif
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/bd_in_handshaker.md
# bd_in_handshaker

Bridges the asynchronous 4-phase bundled-data output port of the BD chip into the FPGA clock domain. It produces a 34-bit valid/ack channel that feeds the BD word decoder directly. It synchronizes BD's request, captures the 34-bit word into a registered output stage and drives BD's acknowledge. A new word is accepted only when the output register is free or is draining in the same cycle.

## Interface
- SYNC_STAGES, 2: number of flops in the req synchronizer (≥2).
- NBITS, 34: BD word width; must match the decoder input channel width.
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset (asserted when 0).
- pin_req  in  1  BD request, asynchronous to clk.
- pin_data  in  NBITS  BD word, bundled with pin_req: stable from before req rises until ack rises.
- pin_ack  out  1  acknowledge to BD, registered.
- BD_out.v  out  1  output channel valid.
- BD_out.d  out  NBITS  output channel data.
- BD_out.a  in  1  output channel ack; a transfer occurs on a cycle with v && a.
- words_received  out  32  count of captured words (present only with BD_IN_COUNT_EN).

## Operation
- req_s is pin_req after SYNC_STAGES flops. pin_data is never synchronized; it is sampled only on the capture cycle.
- States:
  - RESYNC (reset state): waits for req_s == 0, then goes to IDLE.
  - IDLE: waits for capture.
  - ACKED: pin_ack = 1; waits for req_s == 0, then drops ack and returns to IDLE.
- Capture condition: state == IDLE && req_s && (!BD_out.v || BD_out.a).
- On capture:
  - BD_out.d <= pin_data and BD_out.v <= 1.
  - pin_ack <= 1 and state <= ACKED.
  - The counter increments.
- On a transfer without a capture in the same cycle, BD_out.v <= 0.
- Transfer and capture in the same cycle: v stays 1 and d is replaced with the new word (back-to-back, no bubble).
- BD_out.d is held stable while v = 1 and no transfer has occurred.
- Output full with req_s high in IDLE: no capture and ack stays low. BD stalls until the channel drains.
- In ACKED, req_s rising again before ack falls is impossible under the 4-phase protocol and is ignored.
- Counter wraps modulo 2^32.

## Timing
- pin_req rise to capture cycle: SYNC_STAGES+1 clk edges, with ±1 cycle uncertainty from asynchronous sampling.
- BD_out.v and pin_ack rise on the same edge (the capture edge).
- pin_req fall to pin_ack fall: SYNC_STAGES+1 edges.
- Minimum BD cycle: 2·(SYNC_STAGES+1) clk cycles per word.
- Reset values:
  - pin_ack = 0, BD_out.v = 0, BD_out.d = 0.
  - State = RESYNC; synchronizer flops = 0.
  - words_received = 0.
- Reset mid-handshake: ack drops immediately and any pending output word is discarded. The word BD is still holding (req high) is not recaptured, because RESYNC requires req low first.

## Configuration
- BD_IN_COUNT_EN defined: the words_received port and its 32-bit counter exist and increment once per capture.
- BD_IN_COUNT_EN undefined: the port and counter are absent; all other behaviour is identical.

## Structure
- A shared package holds:
  - the state enum (RESYNC, IDLE, ACKED);
  - the BD word width constant, so the decoder and this block share one definition;
  - the SYNC_STAGES default.
- One sub-module: bd_sync_bit, an N-stage single-bit synchronizer, reset to 0. It is reused for other async BD inputs.

## Test plan
- Single word:
  - Stimulus: pin_data=34'h2_DEAD_BEEF, req↑, sink ack held 1.
  - Response: BD_out.d=34'h2_DEAD_BEEF with v for exactly one cycle; ack↑ on the same edge as v; ack↓ 3 cycles after req↓.
- Back-pressure:
  - Stimulus: sink ack=0, two words sent.
  - Response: the first is held with stable d; ack for the second stays low until the sink drains; no word is lost or duplicated.
- Back-to-back:
  - Stimulus: sink ack=1; 100 random words from a 4-phase BD model.
  - Response: the output sequence equals the input sequence in order; words_received=100.
- Simultaneous transfer and capture:
  - Stimulus: the second word's req_s arrives on the same cycle the first transfers.
  - Response: v stays high and d updates the next cycle.
- Reset mid-handshake:
  - Stimulus: reset=0 for 1 cycle while ACKED and req high.
  - Response: ack=0 and v=0; no capture until req↓ then the next req↑.
- Counter wrap (BD_IN_COUNT_EN):
  - Stimulus: force the count to 32'hFFFF_FFFF, then send one word.
  - Response: words_received=0.
